// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - configurable pulse burst generator (finite or continuous)
module pulse_burst_gen #(
    parameter int   WIDTH      = 8,
    parameter int   CWIDTH     = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [WIDTH-1:0]  high_len,
    input  logic [WIDTH-1:0]  low_len,
    input  logic [CWIDTH-1:0] pulse_count,
    output logic              signal,
    output logic              busy,
    output logic              done,
    output logic [CWIDTH-1:0] pulse_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [WIDTH-1:0]  ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0] ONE_C  = {{(CWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0] PD_MAX = {CWIDTH{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  high_len_q, high_len_d;
    logic [WIDTH-1:0]  low_len_q, low_len_d;
    logic [CWIDTH-1:0] pulse_count_q, pulse_count_d;
    logic [CWIDTH-1:0] pulse_done_q, pulse_done_d;
    logic [CWIDTH-1:0] pulse_inc;
    logic              cont_q, cont_d;
    logic              done_q, done_d;
    logic              signal_q, signal_d;

    // Counter holds cycles remaining in the phase minus one; zero length behaves as one.
    function automatic logic [WIDTH-1:0] phase_load(input logic [WIDTH-1:0] len);
        return (len == '0) ? '0 : len - ONE_W;
    endfunction

    assign pulse_inc = (pulse_done_q == PD_MAX) ? pulse_done_q : pulse_done_q + ONE_C;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_len_d    = high_len_q;
        low_len_d     = low_len_q;
        pulse_count_d = pulse_count_q;
        cont_d        = cont_q;
        pulse_done_d  = pulse_done_q;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    high_len_d    = high_len;
                    low_len_d     = low_len;
                    pulse_count_d = pulse_count;
                    cont_d        = continuous;
                    pulse_done_d  = '0;
                    if (!continuous && pulse_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = phase_load(high_len);
                    end
                end
            end
            ST_HIGH: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = phase_load(low_len_q);
                end else begin
                    cnt_d = cnt_q - ONE_W;
                end
            end
            ST_LOW: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    pulse_done_d = pulse_inc;
                    if (!cont_q && pulse_inc == pulse_count_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = phase_load(high_len_q);
                    end
                end else begin
                    cnt_d = cnt_q - ONE_W;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        signal_d = (state_d == ST_HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            high_len_q    <= '0;
            low_len_q     <= '0;
            pulse_count_q <= '0;
            cont_q        <= 1'b0;
            pulse_done_q  <= '0;
            done_q        <= 1'b0;
            signal_q      <= IDLE_LEVEL;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_len_q    <= high_len_d;
            low_len_q     <= low_len_d;
            pulse_count_q <= pulse_count_d;
            cont_q        <= cont_d;
            pulse_done_q  <= pulse_done_d;
            done_q        <= done_d;
            signal_q      <= signal_d;
        end
    end

    assign signal     = signal_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign pulse_done = pulse_done_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb/tb_pulse_burst_gen.sv - scoreboard bench for pulse_burst_gen
module tb_pulse_burst_gen;

    typedef struct packed {
        logic       act;
        logic       busy;
        logic       done;
        logic [3:0] pd;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] high_len = '0;
    logic [7:0] low_len = '0;
    logic [3:0] pulse_count = '0;
    logic       sig_a, busy_a, done_a;
    logic       sig_b, busy_b, done_b;
    logic [3:0] pd_a, pd_b;

    int         total = 0;
    int         bad = 0;
    exp_t       exp_q[$];
    exp_t       trace[$];
    logic [3:0] model_pd = '0;

    pulse_burst_gen #(.WIDTH(8), .CWIDTH(4), .IDLE_LEVEL(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
        .continuous(continuous), .high_len(high_len), .low_len(low_len),
        .pulse_count(pulse_count), .signal(sig_a), .busy(busy_a),
        .done(done_a), .pulse_done(pd_a)
    );

    pulse_burst_gen #(.WIDTH(8), .CWIDTH(4), .IDLE_LEVEL(1'b1)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
        .continuous(continuous), .high_len(high_len), .low_len(low_len),
        .pulse_count(pulse_count), .signal(sig_b), .busy(busy_b),
        .done(done_b), .pulse_done(pd_b)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] sat(input int k);
        return (k > 15) ? 4'd15 : 4'(k);
    endfunction

    // Expected observation after each edge E0..E(len-1); start sampled at E0, stop at E(s).
    task automatic gen_trace(input int h, input int l, input int n, input bit cont,
                             input int s, input int len);
        int eh = (h == 0) ? 1 : h;
        int el = (l == 0) ? 1 : l;
        int k = 0;
        exp_t e;
        trace.delete();
        if (s == 0) begin
            for (int i = 0; i < len; i++) trace.push_back('{1'b0, 1'b0, 1'b0, model_pd});
            return;
        end
        if (!cont && n == 0) begin
            trace.push_back('{1'b0, 1'b0, 1'b1, 4'd0});
        end else begin
            while (trace.size() < len && (cont || k < n)) begin
                for (int i = 0; i < eh; i++) trace.push_back('{1'b1, 1'b1, 1'b0, sat(k)});
                for (int i = 0; i < el; i++) trace.push_back('{1'b0, 1'b1, 1'b0, sat(k)});
                k++;
            end
            if (!cont) trace.push_back('{1'b0, 1'b0, 1'b1, sat(n)});
        end
        while (trace.size() < len) begin
            e = trace[trace.size()-1];
            trace.push_back('{1'b0, 1'b0, 1'b0, e.pd});
        end
        while (trace.size() > len) void'(trace.pop_back());
        if (s > 0 && s < len && trace[s-1].busy) begin
            e = trace[s-1];
            for (int i = s; i < len; i++) trace[i] = '{1'b0, 1'b0, 1'b0, e.pd};
        end
        model_pd = trace[len-1].pd;
    endtask

    // Called at negedge+1; stimulus for edge E(i) is applied in the cycle before it.
    task automatic run_txn(input int h, input int l, input int n, input bit cont,
                           input int s, input int len, input bit disturb);
        bit dist_now;
        gen_trace(h, l, n, cont, s, len);
        dist_now = disturb && (len > 2) && trace[1].busy;
        foreach (trace[i]) exp_q.push_back(trace[i]);
        for (int i = 0; i < len; i++) begin
            start = (i == 0) || (dist_now && i == 2);
            stop  = (i == s);
            if (i == 0) begin
                high_len = 8'(h); low_len = 8'(l); pulse_count = 4'(n); continuous = cont;
            end else begin
                high_len    = (i == 2) ? 8'd9 : 8'($urandom_range(0, 255));
                low_len     = 8'($urandom_range(0, 255));
                pulse_count = 4'($urandom_range(0, 15));
                continuous  = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            #1;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (sig_a !== e.act || sig_b !== ~e.act || busy_a !== e.busy || busy_b !== e.busy ||
                    done_a !== e.done || done_b !== e.done || pd_a !== e.pd || pd_b !== e.pd) begin
                    bad++;
                    $display("FAIL cycle t=%0t: got sig=%b/%b busy=%b/%b done=%b/%b pd=%0d/%0d want act=%b busy=%b done=%b pd=%0d",
                             $time, sig_a, sig_b, busy_a, busy_b, done_a, done_b, pd_a, pd_b,
                             e.act, e.busy, e.done, e.pd);
                end
            end
        end
    end

    initial begin : stim
        int h, l, n, s, len, eh, el;
        bit c, d;
        repeat (2) @(negedge clock);
        #1;
        check_now("reset_state", {sig_a, sig_b, busy_a, done_a, pd_a}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        reset_n = 1'b1;

        run_txn(3, 3, 3, 1'b0, -1, 21, 1'b0);
        run_txn(0, 0, 2, 1'b0, -1, 6, 1'b0);
        run_txn(2, 1, 0, 1'b1, 10, 13, 1'b0);
        run_txn(3, 2, 2, 1'b0, -1, 14, 1'b1);
        run_txn(4, 4, 0, 1'b0, -1, 3, 1'b0);
        run_txn(3, 3, 2, 1'b0, 0, 4, 1'b0);
        run_txn(2, 2, 2, 1'b0, 8, 11, 1'b0);
        run_txn(1, 1, 1, 1'b0, 4, 6, 1'b0);
        run_txn(0, 0, 0, 1'b1, 40, 42, 1'b0);
        run_txn(255, 0, 1, 1'b0, -1, 258, 1'b0);

        for (int t = 0; t < 30; t++) begin
            h = $urandom_range(0, 4);
            l = $urandom_range(0, 4);
            n = $urandom_range(0, 15);
            c = ($urandom_range(0, 3) == 0);
            d = 1'($urandom_range(0, 1));
            eh = (h == 0) ? 1 : h;
            el = (l == 0) ? 1 : l;
            if (c) begin
                s = $urandom_range(1, 40);
                len = s + $urandom_range(1, 3);
            end else begin
                len = n * (eh + el) + 1 + $urandom_range(0, 3);
                if (len < 3) len = 3;
                s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            end
            run_txn(h, l, n, c, s, len, d);
        end

        // Abort with reset between edges while in the third HIGH phase.
        run_txn(1, 1, 5, 1'b0, -1, 5, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_now("async_reset", {sig_a, sig_b, busy_a, busy_b, done_a, pd_a}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        @(negedge clock);
        #1;
        check_now("reset_hold", {sig_a, busy_a, done_a, pd_a, pd_b}, {1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
        reset_n = 1'b1;
        model_pd = '0;
        run_txn(2, 1, 1, 1'b0, -1, 5, 1'b0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of the high_len and low_len phase-length fields.
- REQ-002 The block SHALL have parameter CWIDTH, default 4: bit width of the pulse_count field and of pulse_done.
- REQ-003 The block SHALL have parameter IDLE_LEVEL, default 1'b0: level driven on signal when no burst is running.
- REQ-004 The block SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
- REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin a burst.
- REQ-007 The block SHALL have port stop, input, 1 bit: abort request.
- REQ-008 The block SHALL have port continuous, input, 1 bit: selects the mode (0 = finite burst, 1 = repeat until stop).
- REQ-009 The block SHALL have port high_len, input, WIDTH bits: active-phase length in clock cycles.
- REQ-010 The block SHALL have port low_len, input, WIDTH bits: inactive-phase length in clock cycles.
- REQ-011 The block SHALL have port pulse_count, input, CWIDTH bits: number of pulses per burst.
- REQ-012 The block SHALL have port signal, output, 1 bit: the generated pulse train.
- REQ-013 The block SHALL have port busy, output, 1 bit: burst in progress.
- REQ-014 The block SHALL have port done, output, 1 bit: one-cycle strobe on normal burst completion.
- REQ-015 The block SHALL have port pulse_done, output, CWIDTH bits: number of pulses completed in the current or last burst.

Function
- REQ-016 The FSM SHALL have exactly three states: IDLE, HIGH, LOW.
- REQ-017 In IDLE, start=1 and stop=0 at a rising edge SHALL do all of: latch high_len, low_len, pulse_count and continuous; clear pulse_done; enter HIGH.
- REQ-018 Latched configuration SHALL remain constant for the whole burst; input changes while busy SHALL have no effect.
- REQ-019 A start pulse received while busy=1 SHALL be ignored (no restart, no queuing).
- REQ-020 The block SHALL drive signal=~IDLE_LEVEL in HIGH and signal=IDLE_LEVEL in LOW and IDLE; signal SHALL be a registered output.
- REQ-021 HIGH SHALL last max(high_len,1) cycles and LOW SHALL last max(low_len,1) cycles; a zero length is treated as 1.
- REQ-022 Transition HIGH->LOW SHALL occur at the edge that completes the high phase.
- REQ-023 At the edge that completes the low phase, pulse_done SHALL increment by one (saturating at 2^CWIDTH-1).
- REQ-024 In finite mode, if the completed pulse is number latched pulse_count, the FSM SHALL go to IDLE and assert done for exactly one cycle; otherwise it SHALL go to HIGH.
- REQ-025 In continuous mode, the FSM SHALL go LOW->HIGH indefinitely, pulse_count is ignored, and done SHALL never assert.
- REQ-026 A start with latched pulse_count=0 in finite mode SHALL leave the FSM in IDLE, assert done for one cycle on the next cycle, generate no pulse, and keep busy low.
- REQ-027 The block SHALL drive busy=1 exactly when the state is HIGH or LOW.
- REQ-028 Latency SHALL be as follows: start sampled at edge E0 -> signal active in the cycle after E0.
- REQ-029 stop=1 at any edge while busy SHALL force IDLE at that edge: signal=IDLE_LEVEL, busy=0, done=0, pulse_done holds its value.
- REQ-030 When start and stop are both asserted in IDLE, stop SHALL win and the block SHALL remain in IDLE.
- REQ-031 A stop asserted in IDLE SHALL have no effect.
- REQ-032 When stop coincides with the final low-phase completion, stop SHALL win: done SHALL not assert, and pulse_done SHALL not increment.
- REQ-033 Phase counters SHALL be WIDTH bits and SHALL never wrap; all-ones values produce 2^WIDTH-1 cycles.

Reset
- REQ-034 reset_n=0 SHALL, asynchronously and without waiting for a clock edge, force state IDLE, signal=IDLE_LEVEL, busy=0, done=0, pulse_done=0, and clear phase counters and latched configuration.
- REQ-035 Reset asserted mid-burst SHALL abort immediately with no done strobe.
- REQ-036 After release, the first start SHALL be honoured at the first rising edge with reset_n=1.

Verification
- REQ-037 Finite-burst scenario: high_len=3, low_len=3, pulse_count=3, start at E0 -> signal high in the cycles after E0-E2, E6-E8 and E12-E14 and low otherwise; busy falls at E18; done is high one cycle after E18; pulse_done=3.
- REQ-038 Zero-length scenario: high_len=0, low_len=0, pulse_count=2 -> alternating 1,0,1,0 then IDLE; done after E4.
- REQ-039 Continuous-mode scenario: continuous=1, high_len=2, low_len=1, stop at E10 -> period-3 waveform; signal=IDLE_LEVEL and busy=0 after E10; no done.
- REQ-040 Restart-and-reconfigure scenario: start re-pulsed at E2 with high_len changed to 9 -> ignored; the waveform is unchanged from the first burst.
- REQ-041 Async-reset scenario: reset_n driven low between edges during HIGH -> signal, busy and pulse_done go to 0 before the next edge.
- REQ-042 Boundary scenario: pulse_count=0 -> done one cycle after start with no pulse; simultaneous start and stop in IDLE -> no activity; IDLE_LEVEL=1 -> the waveform is inverted.
